// File: rtl/zxuno_uart.sv
// zxuno_uart: 8N1 UART peripheral on the ZX-Uno register bus.
// UARTDATA: write starts a single-byte TX, read returns the RX FIFO head.
// UARTSTAT: {rx_avail, tx_busy, rx_ovf, rx_ferr, 4'b0000}; a read clears the sticky flags.
module zxuno_uart #(
  parameter int unsigned CLK_HZ    = 28000000,
  parameter int unsigned BAUD      = 115200,
  parameter logic [7:0]  ADDR_DATA = 8'hC6,
  parameter logic [7:0]  ADDR_STAT = 8'hC7,
  parameter int unsigned FIFO_LOG2 = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] zxuno_addr,
  input  logic       zxuno_regrd,
  input  logic       zxuno_regwr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       oe_n,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic       uart_rts_n
);

  localparam int unsigned DIV   = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int unsigned HALF  = DIV / 2;
  localparam int unsigned CW    = $clog2(DIV + 1);
  localparam int unsigned DEPTH = 2 ** FIFO_LOG2;
  localparam int unsigned CNTW  = FIFO_LOG2 + 1;

  localparam logic [CW-1:0]   DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0]   HALF_LAST = CW'(HALF - 1);
  localparam logic [CNTW-1:0] RTS_LVL   = CNTW'(DEPTH - 2);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // ---------------- bus strobes ----------------
  logic       r_regwr_d;
  logic       r_regrd_d;
  logic [7:0] r_addr_d;
  logic       w_wr_edge;
  logic       w_rd_end;
  logic       w_rd_data;
  logic       w_rd_stat;

  // Registered copies of the strobes and address for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_regwr_d <= 1'b0;
      r_regrd_d <= 1'b0;
      r_addr_d  <= '0;
    end else begin
      r_regwr_d <= zxuno_regwr;
      r_regrd_d <= zxuno_regrd;
      r_addr_d  <= zxuno_addr;
    end
  end

  // The read-end edge uses the address of the last cycle the read was active.
  assign w_wr_edge = zxuno_regwr & ~r_regwr_d & (zxuno_addr == ADDR_DATA);
  assign w_rd_end  = ~zxuno_regrd & r_regrd_d;
  assign w_rd_data = w_rd_end & (r_addr_d == ADDR_DATA);
  assign w_rd_stat = w_rd_end & (r_addr_d == ADDR_STAT);

  // ---------------- TX ----------------
  tx_state_t     r_tx_st, w_tx_ns;
  logic [CW-1:0] r_tx_cnt, w_tx_cnt_n;
  logic [2:0]    r_tx_bit, w_tx_bit_n;
  logic [7:0]    r_tx_shr, w_tx_shr_n;
  logic          r_tx_line, w_tx_line_n;
  logic          w_tx_busy;
  logic          w_tx_end;

  // TX state, bit timer, shift register and registered line output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tx_st   <= TX_IDLE;
      r_tx_cnt  <= '0;
      r_tx_bit  <= '0;
      r_tx_shr  <= '0;
      r_tx_line <= 1'b1;
    end else begin
      r_tx_st   <= w_tx_ns;
      r_tx_cnt  <= w_tx_cnt_n;
      r_tx_bit  <= w_tx_bit_n;
      r_tx_shr  <= w_tx_shr_n;
      r_tx_line <= w_tx_line_n;
    end
  end

  // TX next state; the line value is derived from the next state so the
  // registered output changes on the same edge as the state.
  always_comb begin
    w_tx_ns    = r_tx_st;
    w_tx_cnt_n = r_tx_cnt + CW'(1);
    w_tx_bit_n = r_tx_bit;
    w_tx_shr_n = r_tx_shr;
    w_tx_end   = (r_tx_cnt == DIV_LAST);
    case (r_tx_st)
      TX_IDLE: begin
        w_tx_cnt_n = '0;
        if (w_wr_edge) begin
          w_tx_ns    = TX_START;
          w_tx_shr_n = din;
        end
      end
      TX_START: begin
        if (w_tx_end) begin
          w_tx_ns    = TX_DATA;
          w_tx_cnt_n = '0;
          w_tx_bit_n = '0;
        end
      end
      TX_DATA: begin
        if (w_tx_end) begin
          w_tx_cnt_n = '0;
          if (r_tx_bit == 3'd7) begin
            w_tx_ns = TX_STOP;
          end else begin
            w_tx_bit_n = r_tx_bit + 3'd1;
            w_tx_shr_n = {1'b0, r_tx_shr[7:1]};
          end
        end
      end
      TX_STOP: begin
        if (w_tx_end) begin
          w_tx_ns    = TX_IDLE;
          w_tx_cnt_n = '0;
        end
      end
      default: w_tx_ns = TX_IDLE;
    endcase
    case (w_tx_ns)
      TX_START: w_tx_line_n = 1'b0;
      TX_DATA:  w_tx_line_n = w_tx_shr_n[0];
      default:  w_tx_line_n = 1'b1;
    endcase
  end

  assign w_tx_busy = (r_tx_st != TX_IDLE);
  assign uart_tx   = r_tx_line;

  // ---------------- RX ----------------
  logic          r_rx_s1, r_rx_s2, r_rx_prev;
  rx_state_t     r_rx_st, w_rx_ns;
  logic [CW-1:0] r_rx_cnt, w_rx_cnt_n;
  logic [2:0]    r_rx_bit, w_rx_bit_n;
  logic [7:0]    r_rx_shr, w_rx_shr_n;
  logic          w_rx_push;
  logic          w_ferr_set;

  // Two-stage synchroniser plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_s1   <= uart_rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end
  end

  // RX state, bit timer and shift register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_st  <= RX_IDLE;
      r_rx_cnt <= '0;
      r_rx_bit <= '0;
      r_rx_shr <= '0;
    end else begin
      r_rx_st  <= w_rx_ns;
      r_rx_cnt <= w_rx_cnt_n;
      r_rx_bit <= w_rx_bit_n;
      r_rx_shr <= w_rx_shr_n;
    end
  end

  // RX next state. After a framing error the edge detector needs a high
  // level before the next falling edge, which gives the wait-for-idle.
  always_comb begin
    w_rx_ns    = r_rx_st;
    w_rx_cnt_n = r_rx_cnt + CW'(1);
    w_rx_bit_n = r_rx_bit;
    w_rx_shr_n = r_rx_shr;
    w_rx_push  = 1'b0;
    w_ferr_set = 1'b0;
    case (r_rx_st)
      RX_IDLE: begin
        w_rx_cnt_n = '0;
        if (r_rx_prev & ~r_rx_s2) w_rx_ns = RX_START;
      end
      RX_START: begin
        if (r_rx_cnt == HALF_LAST) begin
          w_rx_cnt_n = '0;
          w_rx_bit_n = '0;
          w_rx_ns    = r_rx_s2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (r_rx_cnt == DIV_LAST) begin
          w_rx_cnt_n = '0;
          w_rx_shr_n = {r_rx_s2, r_rx_shr[7:1]};
          if (r_rx_bit == 3'd7) w_rx_ns = RX_STOP;
          else                  w_rx_bit_n = r_rx_bit + 3'd1;
        end
      end
      RX_STOP: begin
        if (r_rx_cnt == DIV_LAST) begin
          w_rx_cnt_n = '0;
          w_rx_ns    = RX_IDLE;
          if (r_rx_s2) w_rx_push  = 1'b1;
          else         w_ferr_set = 1'b1;
        end
      end
      default: w_rx_ns = RX_IDLE;
    endcase
  end

  // ---------------- FIFO and flags ----------------
  logic [7:0]           r_mem [DEPTH];
  logic [FIFO_LOG2-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNTW-1:0]      r_cnt;
  logic                 r_ovf, r_ferr;
  logic                 w_empty, w_full, w_pop, w_push_ok, w_ovf_set;

  assign w_empty   = (r_cnt == '0);
  assign w_full    = r_cnt[FIFO_LOG2];
  assign w_pop     = w_rd_data & ~w_empty;
  assign w_push_ok = w_rx_push & (~w_full | w_pop);
  assign w_ovf_set = w_rx_push & w_full & ~w_pop;

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= r_rx_shr;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Sticky error flags; a set in the clearing cycle wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf  <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      r_ovf  <= w_ovf_set  | (r_ovf  & ~w_rd_stat);
      r_ferr <= w_ferr_set | (r_ferr & ~w_rd_stat);
    end
  end

  assign uart_rts_n = (r_cnt >= RTS_LVL);

  // ---------------- read mux ----------------
  // Register read data toward the CPU data-in mux.
  always_comb begin
    dout = '0;
    if (zxuno_addr == ADDR_DATA) begin
      if (!w_empty) dout = r_mem[r_rd_ptr];
    end else if (zxuno_addr == ADDR_STAT) begin
      dout = {~w_empty, w_tx_busy, r_ovf, r_ferr, 4'b0000};
    end
  end

  assign oe_n = ~(zxuno_regrd & ((zxuno_addr == ADDR_DATA) | (zxuno_addr == ADDR_STAT)));

endmodule

// File: tb/tb_zxuno_uart.sv
// Scoreboard bench for zxuno_uart: stimulus pushes expected bus reads and TX
// frames into queues; independent monitors pop and compare.
module tb_zxuno_uart;

  localparam int unsigned DIV   = 243;
  localparam logic [7:0]  AD    = 8'hC6;
  localparam logic [7:0]  AS    = 8'hC7;
  localparam int unsigned DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] zxuno_addr = 8'h00;
  logic       zxuno_regrd = 1'b0;
  logic       zxuno_regwr = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       oe_n;
  logic       uart_rx = 1'b1;
  logic       uart_tx;
  logic       uart_rts_n;

  zxuno_uart #(
    .CLK_HZ(28000000), .BAUD(115200), .ADDR_DATA(8'hC6), .ADDR_STAT(8'hC7), .FIFO_LOG2(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .zxuno_addr(zxuno_addr), .zxuno_regrd(zxuno_regrd),
    .zxuno_regwr(zxuno_regwr), .din(din), .dout(dout), .oe_n(oe_n),
    .uart_rx(uart_rx), .uart_tx(uart_tx), .uart_rts_n(uart_rts_n)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [7:0]  mdl_fifo[$];
  logic        mdl_ovf  = 1'b0;
  logic        mdl_ferr = 1'b0;
  int unsigned mdl_tx_end = 0;

  typedef struct { logic [7:0] addr; logic [7:0] val; } rdexp_t;
  typedef struct { logic [7:0] data; int unsigned wcyc; } txexp_t;
  rdexp_t exp_rd[$];
  txexp_t exp_tx[$];

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (cyc %0d)", name, act, req, cyc);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Keep register accesses clear of the TX busy->idle transition.
  task automatic avoid_tx_edge();
    while (mdl_tx_end != 0 && cyc + 16 >= mdl_tx_end && cyc <= mdl_tx_end + 16) tick();
  endtask

  task automatic bus_read(input logic [7:0] a);
    rdexp_t e;
    avoid_tx_edge();
    e.addr = a;
    e.val  = 8'h00;
    if (a == AD) begin
      if (mdl_fifo.size() != 0) e.val = mdl_fifo[0];
    end else begin
      e.val[7] = (mdl_fifo.size() != 0);
      e.val[6] = (cyc < mdl_tx_end);
      e.val[5] = mdl_ovf;
      e.val[4] = mdl_ferr;
    end
    exp_rd.push_back(e);
    zxuno_addr  = a;
    zxuno_regrd = 1'b1;
    repeat (4) tick();
    zxuno_regrd = 1'b0;
    repeat (2) tick();
    zxuno_addr = 8'h00;
    if (a == AD && mdl_fifo.size() != 0) void'(mdl_fifo.pop_front());
    if (a == AS) begin
      mdl_ovf  = 1'b0;
      mdl_ferr = 1'b0;
    end
  endtask

  task automatic bus_write(input logic [7:0] v);
    txexp_t t;
    avoid_tx_edge();
    zxuno_addr  = AD;
    din         = v;
    zxuno_regwr = 1'b1;
    tick();
    if (cyc >= mdl_tx_end) begin
      t.data = v;
      t.wcyc = cyc;
      exp_tx.push_back(t);
      mdl_tx_end = cyc + 10 * DIV;
    end
    repeat (3) tick();
    zxuno_regwr = 1'b0;
    tick();
    zxuno_addr = 8'h00;
  endtask

  task automatic send_rx(input logic [7:0] v, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, v, 1'b0};
    for (int unsigned k = 0; k < 10; k++) begin
      uart_rx = bits[k];
      repeat (DIV) tick();
    end
    uart_rx = 1'b1;
    repeat (8) tick();
    if (stop_bit) begin
      if (mdl_fifo.size() < DEPTH) mdl_fifo.push_back(v);
      else                         mdl_ovf = 1'b1;
    end else begin
      mdl_ferr = 1'b1;
    end
  endtask

  // Read monitor: compares dout on the second cycle of every oe_n-low window.
  initial begin
    int     low;
    rdexp_t e;
    low = 0;
    forever begin
      @(negedge clk);
      if (oe_n === 1'b0) low++;
      else               low = 0;
      if (low == 2) begin
        if (exp_rd.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rd_unexpected: got dout %0h, want no read", dout);
        end else begin
          e = exp_rd.pop_front();
          check((e.addr == AS) ? "rd_stat" : "rd_data", {24'h0, dout}, {24'h0, e.val});
        end
      end
    end
  end

  // TX monitor: decodes each frame, sampling near both ends of every bit.
  initial begin
    logic        prev;
    logic [9:0]  got_a, got_b, want;
    int unsigned t0;
    txexp_t      e;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev === 1'b1 && uart_tx === 1'b0) begin
        t0 = cyc;
        for (int unsigned k = 0; k < 10; k++) begin
          @(negedge clk);
          got_a[k] = uart_tx;
          repeat (DIV - 3) @(negedge clk);
          got_b[k] = uart_tx;
          repeat (2) @(negedge clk);
        end
        if (exp_tx.size() == 0) begin
          total++;
          bad++;
          $display("FAIL tx_unexpected: got frame %0h, want none", got_a);
        end else begin
          e = exp_tx.pop_front();
          want = {1'b1, e.data, 1'b0};
          check("tx_frame_early", {22'h0, got_a}, {22'h0, want});
          check("tx_frame_late",  {22'h0, got_b}, {22'h0, want});
          check("tx_start_latency_ok", {31'h0, (t0 - e.wcyc) <= DIV}, 32'd1);
        end
        prev = 1'b1;
      end else begin
        prev = uart_tx;
      end
    end
  end

  // Watchdog against a hung run.
  initial begin
    repeat (99000) @(posedge clk);
    $display("FAIL watchdog: got timeout at cyc %0d, want completion", cyc);
    $fatal(1);
  end

  initial begin
    int unsigned op;
    // 1: reset
    rst_n = 1'b0;
    repeat (5) tick();
    check("rst_uart_tx", {31'h0, uart_tx}, 32'd1);
    check("rst_rts_n",   {31'h0, uart_rts_n}, 32'd0);
    rst_n = 1'b1;
    tick();
    zxuno_addr  = 8'h00;
    zxuno_regrd = 1'b1;
    tick();
    check("oe_n_other_addr", {31'h0, oe_n}, 32'd1);
    zxuno_regrd = 1'b0;
    tick();
    bus_read(AS);

    // 2/3: TX of A5, second write while busy is dropped
    bus_write(8'hA5);
    repeat (50) tick();
    bus_write(8'h3C);
    repeat (1000) tick();
    bus_read(AS);
    while (cyc < mdl_tx_end + 50) tick();
    bus_read(AS);

    // 4: RX single frame
    send_rx(8'h5A, 1'b1);
    bus_read(AS);
    bus_read(AD);
    bus_read(AS);

    // 5: overflow with 17 frames, RTS threshold
    for (int unsigned i = 1; i <= 17; i++) begin
      send_rx(8'($urandom), 1'b1);
      if (i == 13) check("rts_n_at_13", {31'h0, uart_rts_n}, 32'd0);
      if (i == 14) check("rts_n_at_14", {31'h0, uart_rts_n}, 32'd1);
    end
    bus_read(AS);
    for (int unsigned i = 0; i < 16; i++) bus_read(AD);
    check("rts_n_drained", {31'h0, uart_rts_n}, 32'd0);
    bus_read(AS);
    bus_read(AD);

    // 6: framing error, then a short glitch
    send_rx(8'($urandom), 1'b0);
    bus_read(AS);
    bus_read(AD);
    bus_read(AS);
    uart_rx = 1'b0;
    repeat (2) tick();
    uart_rx = 1'b1;
    repeat (2 * DIV) tick();
    bus_read(AS);
    bus_read(AD);

    // randomized mix
    for (int unsigned n = 0; n < 8; n++) begin
      op = $urandom_range(0, 3);
      case (op)
        0:       send_rx(8'($urandom), ($urandom_range(0, 4) != 0));
        1:       bus_read(AD);
        2:       bus_read(AS);
        default: bus_write(8'($urandom));
      endcase
    end
    bus_read(AS);
    while (mdl_fifo.size() != 0) bus_read(AD);
    bus_read(AS);

    while (cyc < mdl_tx_end + 3 * DIV) tick();
    repeat (10) tick();
    check("tx_frames_pending", exp_tx.size(), 32'd0);
    check("rd_pending",        exp_rd.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
